rw_manager_inst_store: RTL and testbench

Parametrised, writable instruction store for the rw_manager. It replaces a fixed instruction ROM with an internal RAM. After reset or on request, the RAM is loaded from an external default-image ROM through a copy engine. The sequencer can then patch individual words through a write port and fetch words through a read port with configurable latency.

---
 rtl/rw_manager_inst_store.sv | 184 ++++++++++++++++++
 tb/tb_rw_manager_inst_store.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_manager_inst_store.sv
// Writable instruction store for the rw_manager: a simple dual-port RAM filled from a
// default-image ROM by a copy engine, then patched and fetched by the sequencer.
module rw_manager_inst_store #(
  parameter int DATA_WIDTH   = 20,
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_LATENCY = 1,
  parameter int AUTO_INIT    = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam state_e ST_RESET = (AUTO_INIT != 0) ? ST_COPY : ST_IDLE;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH-1:0]   cp_addr_q, cp_addr_d;
  logic                    cp_valid_q, cp_valid_d;
  logic                    init_done_q, init_done_d;
  logic                    wr_err_q, wr_err_d;
  logic [DATA_WIDTH-1:0]   q_q;
  logic                    q_valid_q;

  logic                    copy_start, copy_step, copy_finish;
  logic                    seq_wr, rd_accept;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the processes can be written in any order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_RESET;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (init_start) state_d = ST_COPY;
      ST_COPY:  if (rom_addr_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The sequencer only owns the RAM ports while the copy engine is idle.
  always_comb begin
    init_busy   = 1'b1;
    copy_start  = 1'b0;
    copy_step   = 1'b0;
    copy_finish = 1'b0;
    seq_wr      = 1'b0;
    rd_accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        init_busy  = 1'b0;
        copy_start = init_start;
        seq_wr     = wr_en;
        rd_accept  = rd_en;
      end
      ST_COPY:  copy_step   = 1'b1;
      ST_DRAIN: copy_finish = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (copy_start) begin
      rom_addr_d = '0;
    end else if (copy_step && (rom_addr_q != LAST_ADDR)) begin
      rom_addr_d = rom_addr_q + 1'b1;
    end

    // ROM data lags its address by one cycle, so the write address lags too.
    cp_addr_d  = rom_addr_q;
    cp_valid_d = copy_step;

    init_done_d = init_done_q;
    if (copy_start)       init_done_d = 1'b0;
    else if (copy_finish) init_done_d = 1'b1;

    wr_err_d = wr_en & init_busy;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rom_addr_q  <= '0;
      cp_addr_q   <= '0;
      cp_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      cp_addr_q   <= cp_addr_d;
      cp_valid_q  <= cp_valid_d;
      init_done_q <= init_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // cp_valid_q is only ever set in COPY/DRAIN and seq_wr only in IDLE, so the
  // two writers never collide.
  always_comb begin
    ram_we    = cp_valid_q | seq_wr;
    ram_waddr = cp_valid_q ? cp_addr_q : wr_addr;
    ram_wdata = cp_valid_q ? rom_data  : wr_data;
  end

  // NOTE: the RAM array has no reset; a reset port would prevent block-RAM inference,
  // and the copy engine provides the defined contents instead.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Reads sample mem in a separate process from the write, which gives read-first
  // behaviour on a same-address collision. Any latency other than 2 builds the 1-cycle path.
  generate
    if (READ_LATENCY == 2) begin : g_rd_lat2
      logic [DATA_WIDTH-1:0] ram_dout_q;
      logic                  ram_dout_valid_q;

      always_ff @(posedge clock) begin
        if (rd_accept) ram_dout_q <= mem[rdaddress];
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          ram_dout_valid_q <= 1'b0;
          q_valid_q        <= 1'b0;
          q_q              <= '0;
        end else begin
          ram_dout_valid_q <= rd_accept;
          q_valid_q        <= ram_dout_valid_q;
          if (ram_dout_valid_q) q_q <= ram_dout_q;
        end
      end
    end else begin : g_rd_lat1
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          q_valid_q <= 1'b0;
          q_q       <= '0;
        end else begin
          q_valid_q <= rd_accept;
          if (rd_accept) q_q <= mem[rdaddress];
        end
      end
    end
  endgenerate

  assign rom_addr  = rom_addr_q;
  assign init_done = init_done_q;
  assign wr_err    = wr_err_q;
  assign q         = q_q;
  assign q_valid   = q_valid_q;

endmodule

// File: tb/tb_rw_manager_inst_store.sv
// Bench for rw_manager_inst_store: instance a (latency 1, auto-init) and instance b
// (latency 2, manual init) share stimulus and are checked against a behavioural model.
module tb_rw_manager_inst_store;

  localparam int DW    = 20;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn, init_start, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rdaddress;
  logic [DW-1:0] wr_data;

  logic          busy_a, done_a, werr_a, qv_a;
  logic [AW-1:0] rom_addr_a;
  logic [DW-1:0] rom_data_a, q_a;
  logic          busy_b, done_b, werr_b, qv_b;
  logic [AW-1:0] rom_addr_b;
  logic [DW-1:0] rom_data_b, q_b;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  rw_manager_inst_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .AUTO_INIT(1)) dut_a (
    .clock(clock), .resetn(resetn), .init_start(init_start), .init_busy(busy_a),
    .init_done(done_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(werr_a), .rd_en(rd_en),
    .rdaddress(rdaddress), .q(q_a), .q_valid(qv_a)
  );

  rw_manager_inst_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .AUTO_INIT(0)) dut_b (
    .clock(clock), .resetn(resetn), .init_start(init_start), .init_busy(busy_b),
    .init_done(done_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(werr_b), .rd_en(rd_en),
    .rdaddress(rdaddress), .q(q_b), .q_valid(qv_b)
  );

  function automatic logic [DW-1:0] img(input int a);
    return DW'((a * 3 + 1) & 32'hFFFFF);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Default-image ROM: registered, data one cycle after address.
  always @(posedge clock) begin
    rom_data_a <= img(int'(rom_addr_a));
    rom_data_b <= img(int'(rom_addr_b));
  end

  // Behavioural model: copy progress counted in edges, RAM as an array, and read
  // results scheduled by the edge on which they become visible.
  logic [DW-1:0] m_mem     [2][DEPTH];
  bit            m_busy    [2];
  bit            m_done    [2];
  bit            m_werr    [2];
  bit            m_qv      [2];
  int            m_cyc     [2];
  int            m_rom     [2];
  logic [DW-1:0] m_q       [2];
  bit            m_sched_v [2][4];
  logic [DW-1:0] m_sched_d [2][4];
  int unsigned   edge_n = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = (k == 0);
        m_cyc[k]  = 0;
        m_done[k] = 1'b0;
        m_werr[k] = 1'b0;
        m_qv[k]   = 1'b0;
        m_q[k]    = '0;
        m_rom[k]  = 0;
        for (int s = 0; s < 4; s++) m_sched_v[k][s] = 1'b0;
      end
    end else begin
      edge_n++;
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k] && rd_en) begin
          m_sched_v[k][(edge_n + lat(k) - 1) % 4] = 1'b1;
          m_sched_d[k][(edge_n + lat(k) - 1) % 4] = m_mem[k][rdaddress];
        end
        m_qv[k] = m_sched_v[k][edge_n % 4];
        if (m_qv[k]) begin
          m_q[k] = m_sched_d[k][edge_n % 4];
          m_sched_v[k][edge_n % 4] = 1'b0;
        end
        m_werr[k] = wr_en && m_busy[k];
        if (m_busy[k]) begin
          m_cyc[k]++;
          if (m_cyc[k] >= 2) m_mem[k][m_cyc[k] - 2] = img(m_cyc[k] - 2);
          m_rom[k] = (m_cyc[k] < DEPTH - 1) ? m_cyc[k] : DEPTH - 1;
          if (m_cyc[k] == DEPTH + 1) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
          end
        end else begin
          if (wr_en) m_mem[k][wr_addr] = wr_data;
          if (init_start) begin
            m_busy[k] = 1'b1;
            m_cyc[k]  = 0;
            m_done[k] = 1'b0;
            m_rom[k]  = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("a.init_busy", 32'(busy_a),     32'(m_busy[0]));
      check("a.init_done", 32'(done_a),     32'(m_done[0]));
      check("a.wr_err",    32'(werr_a),     32'(m_werr[0]));
      check("a.rom_addr",  32'(rom_addr_a), 32'(m_rom[0]));
      check("a.q_valid",   32'(qv_a),       32'(m_qv[0]));
      check("a.q",         32'(q_a),        32'(m_q[0]));
      check("b.init_busy", 32'(busy_b),     32'(m_busy[1]));
      check("b.init_done", 32'(done_b),     32'(m_done[1]));
      check("b.wr_err",    32'(werr_b),     32'(m_werr[1]));
      check("b.rom_addr",  32'(rom_addr_b), 32'(m_rom[1]));
      check("b.q_valid",   32'(qv_b),       32'(m_qv[1]));
      check("b.q",         32'(q_b),        32'(m_q[1]));
    end
  end

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a_fall, b_fall, b_high;

  initial begin
    resetn = 1'b1; init_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rdaddress = '0;
    #1 resetn = 1'b0;
    #1 cmp_en = 1'b1;
    tick; tick;
    check("rst.busy_a", 32'(busy_a), 32'd1);
    check("rst.busy_b", 32'(busy_b), 32'd0);
    check("rst.rom_addr_a", 32'(rom_addr_a), 32'd0);
    check("rst.q_valid_a", 32'(qv_a), 32'd0);
    resetn = 1'b1;

    // Auto copy on a; b started manually at edge 4, re-requested mid-copy.
    a_fall = 0; b_fall = 0; b_high = 0;
    for (int n = 1; n <= 300; n++) begin
      tick;
      init_start = 1'b0;
      wr_en      = 1'b0;
      if (busy_b) b_high++;
      if (a_fall == 0 && !busy_a) a_fall = n;
      if (b_fall == 0 && n > 4 && !busy_b) b_fall = n;
      if (n == 3) begin
        check("idle.rom_addr_b", 32'(rom_addr_b), 32'd0);
        check("idle.busy_b", 32'(busy_b), 32'd0);
        init_start = 1'b1;
      end
      if (n == 24) init_start = 1'b1;
      if (n == 30) begin
        wr_en = 1'b1; wr_addr = 7'h10; wr_data = 20'h12345;
      end
      if (n == 31) begin
        check("busywr.wr_err_a", 32'(werr_a), 32'd1);
        check("busywr.wr_err_b", 32'(werr_b), 32'd1);
      end
      if (n == 50) check("copy.rom_addr_a", 32'(rom_addr_a), 32'd50);
      if (a_fall != 0 && b_fall != 0) break;
    end
    check("copy.a_edges", 32'(a_fall), 32'd129);
    check("copy.b_fall_edge", 32'(b_fall), 32'd133);
    check("copy.b_busy_cycles", 32'(b_high), 32'd129);
    check("copy.done_a", 32'(done_a), 32'd1);
    check("copy.done_b", 32'(done_b), 32'd1);

    rd_en = 1'b1; rdaddress = 7'h1A; tick; rd_en = 1'b0;
    check("rd1a.qv_a", 32'(qv_a), 32'd1);
    check("rd1a.q_a", 32'(q_a), 32'h4F);
    check("rd1a.qv_b_early", 32'(qv_b), 32'd0);
    tick;
    check("rd1a.qv_b", 32'(qv_b), 32'd1);
    check("rd1a.q_b", 32'(q_b), 32'h4F);
    check("rd1a.q_a_hold", 32'(q_a), 32'h4F);

    rd_en = 1'b1; rdaddress = 7'h00; tick;
    check("lat2.qv_b_+1", 32'(qv_b), 32'd0);
    rdaddress = 7'h01; tick;
    check("lat2.q_b_0", 32'(q_b), 32'h00001);
    rdaddress = 7'h02; tick;
    check("lat2.q_b_1", 32'(q_b), 32'h00004);
    rd_en = 1'b0; tick;
    check("lat2.qv_b_2", 32'(qv_b), 32'd1);
    check("lat2.q_b_2", 32'(q_b), 32'h00007);
    tick;
    check("lat2.q_b_hold", 32'(q_b), 32'h00007);

    wr_en = 1'b1; wr_addr = 7'h2A; wr_data = 20'hABCDE; rd_en = 1'b1; rdaddress = 7'h2A; tick;
    wr_en = 1'b0;
    check("rw.old_a", 32'(q_a), 32'h0007F);
    tick;
    check("rw.new_a", 32'(q_a), 32'hABCDE);
    check("rw.old_b", 32'(q_b), 32'h0007F);
    rd_en = 1'b0; tick;
    check("rw.new_b", 32'(q_b), 32'hABCDE);

    wr_en = 1'b1; wr_addr = 7'h11; wr_data = 20'h55555; rd_en = 1'b1; rdaddress = 7'h12; tick;
    wr_en = 1'b0;
    check("indep.rd12", 32'(q_a), 32'h00037);
    rdaddress = 7'h11; tick;
    check("indep.rd11", 32'(q_a), 32'h55555);
    rdaddress = 7'h10; tick;
    check("busywr.rd10", 32'(q_a), 32'h00031);
    rd_en = 1'b0; tick; tick;

    // Reload with a read issued on the same cycle; then reset mid-copy.
    init_start = 1'b1; rd_en = 1'b1; rdaddress = 7'h05; tick;
    init_start = 1'b0; rd_en = 1'b0;
    check("reload.busy_a", 32'(busy_a), 32'd1);
    check("reload.q_a", 32'(q_a), 32'h00010);
    tick;
    check("reload.qv_b", 32'(qv_b), 32'd1);
    check("reload.q_b", 32'(q_b), 32'h00010);
    rd_en = 1'b1; rdaddress = 7'h03;
    for (int i = 0; i < 49; i++) tick;
    rd_en = 1'b0;
    check("reload.qv_a_ignored", 32'(qv_a), 32'd0);
    check("reload.rom_addr_a", 32'(rom_addr_a), 32'd50);
    #1 resetn = 1'b0;
    #1;
    check("midrst.rom_addr_a", 32'(rom_addr_a), 32'd0);
    check("midrst.done_a", 32'(done_a), 32'd0);
    check("midrst.q_a", 32'(q_a), 32'd0);
    check("midrst.busy_a", 32'(busy_a), 32'd1);
    check("midrst.busy_b", 32'(busy_b), 32'd0);
    tick; tick;
    resetn = 1'b1;
    a_fall = 0;
    for (int n = 1; n <= 300; n++) begin
      tick;
      if (!busy_a) begin
        a_fall = n;
        break;
      end
    end
    check("restart.a_edges", 32'(a_fall), 32'd129);
    check("restart.done_a", 32'(done_a), 32'd1);

    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rdaddress = AW'(i);
      tick;
    end
    rd_en = 1'b0;
    check("sweep.last_a", 32'(q_a), 32'h0017E);
    tick; tick;

    // A reset while b still holds a read in flight drops that result.
    rd_en = 1'b1; rdaddress = 7'h07; tick; rd_en = 1'b0;
    check("rdrst.q_a", 32'(q_a), 32'h00016);
    #1 resetn = 1'b0;
    #1;
    check("rdrst.qv_b", 32'(qv_b), 32'd0);
    check("rdrst.q_b", 32'(q_b), 32'd0);
    tick;
    resetn = 1'b1;
    tick; tick;
    check("rdrst.qv_b_after", 32'(qv_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
